pc_fetch_unit: RTL and testbench

Program-counter and instruction-fetch stage for the RV32I core. It holds the architectural PC, issues one word request at a time to instruction memory over a req/gnt/rvalid handshake, and presents the fetched instruction, its PC and PC+4 to decode over a valid/ready handshake. It sits directly downstream of the branch-target adder and the branch/zero AND gate: their outputs drive `redirect_target` and `redirect_valid`, which override sequential fetch.

---
 rtl/pc_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter and instruction-fetch stage of the RV32I core. Holds the
// architectural PC, keeps at most one instruction-memory word request in
// flight (req/gnt/rvalid), and presents the fetched instruction to decode over
// a valid/ready handshake. A redirect from the branch logic overrides
// sequential fetch and cancels any fetch already in flight.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   imem_req/_addr    word fetch request; address is always the current PC
//   imem_gnt          memory accepts the request this cycle
//   imem_rvalid/rdata read response (at least one cycle after grant)
//   redirect_valid    take branch/jump this cycle
//   redirect_target   new PC (bits [1:0] are forced to zero)
//   if_valid/ready    decode handshake
//   if_pc/_plus4      PC of the presented instruction and PC+4
//   if_instr          presented instruction word
//   misalign_err      sticky: some redirect target was not word aligned
//   instr_count       number of completed decode handshakes (wraps)
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr,
  output logic        misalign_err,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,     // first cycle after reset
    S_REQ,      // request driven, waiting for grant
    S_WAIT,     // granted, response owed for the current PC
    S_HOLD,     // instruction presented to decode
    S_DISCARD   // response owed for a fetch cancelled by a redirect
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        misalign_q, misalign_d;
  logic [31:0] count_q, count_d;

  logic [31:0] redirect_pc;
  logic        take_redirect;

  assign redirect_pc = {redirect_target[31:2], 2'b00};

  // NOTE: every variable gets its hold value before the case statement, so no
  // path through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    count_d       = count_q;
    take_redirect = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        if (redirect_valid) begin
          take_redirect = 1'b1;
          // A granted request now fetches the old PC, so its data is stale.
          if (imem_gnt) state_d = S_DISCARD;
        end else if (imem_gnt) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          take_redirect = 1'b1;
          state_d       = imem_rvalid ? S_REQ : S_DISCARD;
        end else if (imem_rvalid) begin
          if_instr_d = imem_rdata;
          if_pc_d    = pc_q;
          state_d    = S_HOLD;
        end
      end

      S_HOLD: begin
        // Redirect beats the handshake: the presented instruction is on the
        // wrong path and must not count as delivered.
        if (redirect_valid) begin
          take_redirect = 1'b1;
          state_d       = S_REQ;
        end else if (if_ready) begin
          pc_d    = pc_q + 32'd4;
          count_d = count_q + 32'd1;
          state_d = S_REQ;
        end
      end

      S_DISCARD: begin
        if (redirect_valid) take_redirect = 1'b1;
        if (imem_rvalid)    state_d = S_REQ;
      end

      default: state_d = S_IDLE;
    endcase

    if (take_redirect) pc_d = redirect_pc;
    misalign_d = misalign_q | (take_redirect & (|redirect_target[1:0]));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      if_instr_q <= 32'h0;
      if_pc_q    <= 32'h0;
      misalign_q <= 1'b0;
      count_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign imem_req     = (state_q == S_REQ);
  assign imem_addr    = pc_q;
  assign if_valid     = (state_q == S_HOLD);
  assign if_pc        = if_pc_q;
  assign if_pc_plus4  = if_pc_q + 32'd4;
  assign if_instr     = if_instr_q;
  assign misalign_err = misalign_q;
  assign instr_count  = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Directed bench for pc_fetch_unit. Instance u_dut (RESET_PC = 0) is driven
// by a small instruction-memory responder with programmable grant enable and
// response latency; instance u_wrap (RESET_PC = 32'hFFFF_FFFC) runs with a
// zero-wait memory and an always-ready decode to exercise PC wrap-around.
// Memory returns addr ^ 32'hA5A5_A5A5 as the instruction word.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_A5A5;

  logic        clk;
  logic        reset;

  // primary instance
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        misalign_err;
  logic [31:0] instr_count;

  // wrap-around instance
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_instr;
  logic        w_misalign;
  logic [31:0] w_count;

  // memory responder controls
  logic        gnt_en;
  int          lat;
  int          mem_cnt;
  logic [31:0] mem_addr;

  int total = 0;
  int bad   = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .if_instr        (if_instr),
    .misalign_err    (misalign_err),
    .instr_count     (instr_count)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (w_req),
    .imem_addr       (w_addr),
    .imem_gnt        (w_req),
    .imem_rvalid     (w_rvalid),
    .imem_rdata      (w_rdata),
    .redirect_valid  (1'b0),
    .redirect_target (32'h0),
    .if_valid        (w_valid),
    .if_ready        (1'b1),
    .if_pc           (w_pc),
    .if_pc_plus4     (w_pc_plus4),
    .if_instr        (w_instr),
    .misalign_err    (w_misalign),
    .instr_count     (w_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Primary memory: response comes lat cycles after the grant cycle.
  assign imem_gnt    = imem_req & gnt_en;
  assign imem_rvalid = (mem_cnt == 1);
  assign imem_rdata  = mem_addr ^ K;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_cnt  <= 0;
      mem_addr <= 32'h0;
    end else if (imem_req && imem_gnt) begin
      mem_cnt  <= lat;
      mem_addr <= imem_addr;
    end else if (mem_cnt != 0) begin
      mem_cnt <= mem_cnt - 1;
    end
  end

  // Wrap instance memory: zero-wait, always granted.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      w_rvalid <= 1'b0;
      w_rdata  <= 32'h0;
    end else begin
      w_rvalid <= w_req;
      w_rdata  <= w_addr ^ K;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset           = 1'b0;
    gnt_en          = 1'b1;
    lat             = 1;
    if_ready        = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;

    // ---- reset values ----
    #1 reset = 1'b1;
    #2;
    check("rst_req",      {31'b0, imem_req},     32'h0);
    check("rst_addr",     imem_addr,             32'h0);
    check("rst_valid",    {31'b0, if_valid},     32'h0);
    check("rst_pc",       if_pc,                 32'h0);
    check("rst_plus4",    if_pc_plus4,           32'h4);
    check("rst_instr",    if_instr,              32'h0);
    check("rst_misalign", {31'b0, misalign_err}, 32'h0);
    check("rst_count",    instr_count,           32'h0);
    check("rst_w_addr",   w_addr,                32'hFFFF_FFFC);

    // ---- sequential fetch, zero-wait memory ----
    @(negedge clk) reset = 1'b0;
    tick();  // edge 1: REQ
    check("e1_req",     {31'b0, imem_req}, 32'h1);
    check("e1_addr",    imem_addr,         32'h0);
    check("e1_valid",   {31'b0, if_valid}, 32'h0);
    check("e1_w_addr",  w_addr,            32'hFFFF_FFFC);
    tick();  // edge 2: WAIT
    check("e2_valid",   {31'b0, if_valid}, 32'h0);
    tick();  // edge 3: HOLD
    check("e3_valid",   {31'b0, if_valid}, 32'h1);
    check("i0_pc",      if_pc,             32'h0);
    check("i0_instr",   if_instr,          32'h0 ^ K);
    check("i0_plus4",   if_pc_plus4,       32'h4);
    check("w_pc",       w_pc,              32'hFFFF_FFFC);
    check("w_plus4",    w_pc_plus4,        32'h0);
    check("w_instr",    w_instr,           32'hFFFF_FFFC ^ K);
    tick();  // handshake -> REQ
    check("i1_addr",    imem_addr,         32'h4);
    check("cnt1",       instr_count,       32'h1);
    check("w_wrap",     w_addr,            32'h0);
    tick();
    tick();
    check("i1_pc",      if_pc,             32'h4);
    check("i1_instr",   if_instr,          32'h4 ^ K);
    tick();
    check("i2_addr",    imem_addr,         32'h8);
    check("cnt2",       instr_count,       32'h2);
    tick();
    tick();
    check("i2_valid",   {31'b0, if_valid}, 32'h1);
    check("i2_pc",      if_pc,             32'h8);

    // ---- decode stall: everything held ----
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", {31'b0, if_valid}, 32'h1);
      check("stall_pc",    if_pc,             32'h8);
      check("stall_instr", if_instr,          32'h8 ^ K);
      check("stall_req",   {31'b0, imem_req}, 32'h0);
      check("stall_cnt",   instr_count,       32'h2);
    end
    if_ready = 1'b1;
    tick();
    check("cnt3",     instr_count,       32'h3);
    check("i3_addr",  imem_addr,         32'hC);

    // ---- no grant: request stays up ----
    gnt_en = 1'b0;
    tick();
    check("nognt_req",  {31'b0, imem_req}, 32'h1);
    check("nognt_addr", imem_addr,         32'hC);
    gnt_en = 1'b1;
    lat    = 2;
    tick();  // WAIT, response owed two cycles after grant

    // ---- redirect in WAIT -> DISCARD ----
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    tick();  // DISCARD
    redirect_valid  = 1'b0;
    check("disc_valid", {31'b0, if_valid}, 32'h0);
    check("disc_req",   {31'b0, imem_req}, 32'h0);
    tick();  // stale rvalid consumed -> REQ
    check("disc_valid2", {31'b0, if_valid}, 32'h0);
    check("redir_addr",  imem_addr,         32'h100);
    check("redir_req",   {31'b0, imem_req}, 32'h1);
    lat = 1;
    tick();
    tick();
    check("redir_valid", {31'b0, if_valid}, 32'h1);
    check("redir_pc",    if_pc,             32'h100);
    check("redir_instr", if_instr,          32'h100 ^ K);
    check("redir_cnt",   instr_count,       32'h3);

    // ---- redirect with ready in HOLD ----
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    tick();
    redirect_valid  = 1'b0;
    check("hold_redir_valid", {31'b0, if_valid},     32'h0);
    check("hold_redir_addr",  imem_addr,             32'h200);
    check("hold_redir_cnt",   instr_count,           32'h3);
    check("hold_no_misalign", {31'b0, misalign_err}, 32'h0);
    tick();
    tick();
    check("i200_pc", if_pc, 32'h200);
    tick();
    check("cnt4",    instr_count, 32'h4);
    check("i204",    imem_addr,   32'h204);

    // ---- misaligned redirect in REQ with grant ----
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0103;
    tick();  // DISCARD
    redirect_valid  = 1'b0;
    check("mis_err",   {31'b0, misalign_err}, 32'h1);
    check("mis_req",   {31'b0, imem_req},     32'h0);
    tick();
    check("mis_addr",  imem_addr,             32'h100);
    tick();
    tick();
    check("mis_pc",     if_pc,                 32'h100);
    check("mis_sticky", {31'b0, misalign_err}, 32'h1);
    tick();
    check("cnt5", instr_count, 32'h5);
    tick();  // WAIT

    // ---- reset mid-transaction ----
    reset = 1'b1;
    #1;
    check("mid_rst_req",   {31'b0, imem_req},     32'h0);
    check("mid_rst_addr",  imem_addr,             32'h0);
    check("mid_rst_valid", {31'b0, if_valid},     32'h0);
    check("mid_rst_mis",   {31'b0, misalign_err}, 32'h0);
    check("mid_rst_cnt",   instr_count,           32'h0);
    check("mid_rst_plus4", if_pc_plus4,           32'h4);
    @(negedge clk) reset = 1'b0;
    tick();
    check("restart_req",  {31'b0, imem_req}, 32'h1);
    check("restart_addr", imem_addr,         32'h0);
    tick();
    tick();
    check("restart_valid", {31'b0, if_valid}, 32'h1);
    check("restart_pc",    if_pc,             32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
